// File: rtl/truth_table_checker.sv
// Exhaustive checker for a 2-input NAND unit: sweeps {x,y} through 00..11 and
// compares the gate-level (a) and expression-level (b) outputs against ~(x&y).
module truth_table_checker #(
  parameter int SETTLE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       a,
  input  logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail,
  output logic       fail_valid
);

  localparam int HW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [HW-1:0] hold;
  logic          expect_n;
  logic          vec_fail;
  logic [2:0]    err_next;

  // One vector can only ever add one error; the count tops out at 4 vectors.
  function automatic logic [2:0] sat_inc(input logic [2:0] cnt, input logic inc);
    if (inc && (cnt < 3'd4))
      return cnt + 3'd1;
    return cnt;
  endfunction

  // {x,y} are registered, so a and b respond to the vector currently held.
  assign expect_n = ~(x & y);
  assign vec_fail = (a != expect_n) || (b != expect_n);
  assign err_next = sat_inc(err_count, vec_fail);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      x          <= 1'b0;
      y          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      first_fail <= 2'b00;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            hold       <= '0;
            x          <= 1'b0;
            y          <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            first_fail <= 2'b00;
            fail_valid <= 1'b0;
          end
        end
        RUN: begin
          if (hold == HOLD_LAST) begin
            hold      <= '0;
            err_count <= err_next;
            if (vec_fail && !fail_valid) begin
              first_fail <= {x, y};
              fail_valid <= 1'b1;
            end
            if ({x, y} == 2'b11) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 3'd0);
              x     <= 1'b0;
              y     <= 1'b0;
            end else begin
              {x, y} <= {x, y} + 2'd1;
            end
          end else begin
            hold <= hold + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
